// File: rtl/bp_be_pkg.sv
// ============================================================================
// Module : bp_be_pkg
// Shared backend definitions: stall-reason bin order and dump FSM encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bp_be_pkg;

   // Bit order of the profiler stall-reason vector; bit 0 has highest priority
   localparam int c_num_reasons = 10;

   typedef enum logic [3:0] {
      e_bin_reason0      = 4'd0,
      e_bin_reason1      = 4'd1,
      e_bin_reason2      = 4'd2,
      e_bin_reason3      = 4'd3,
      e_bin_reason4      = 4'd4,
      e_bin_reason5      = 4'd5,
      e_bin_reason6      = 4'd6,
      e_bin_reason7      = 4'd7,
      e_bin_reason8      = 4'd8,
      e_bin_reason9      = 4'd9,
      e_bin_unattributed = 4'd10,
      e_bin_commit       = 4'd11,
      e_bin_total        = 4'd12
   } bp_stall_bin_e;

   typedef enum logic [0:0] {
      e_dump_idle   = 1'b0,
      e_dump_active = 1'b1
   } bp_stall_dump_state_e;

endpackage

`default_nettype wire

// File: rtl/bp_nonsynth_stall_counter.sv
// ============================================================================
// Module : bp_nonsynth_stall_counter
// One histogram bin: increment/clear counter, saturating when
// BP_NONSYNTH_STALL_HIST_SATURATE_EN is defined, otherwise wrapping with a
// sticky overflow flag. Exposes the post-edge (pre-clear) value for snapshots.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_nonsynth_stall_counter #(
   parameter int cnt_width_p = 32
)(
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   clear_i,
   input  logic                   inc_i,
   output logic [cnt_width_p-1:0] next_count_o
`ifndef BP_NONSYNTH_STALL_HIST_SATURATE_EN
   ,
   output logic                   next_overflow_o
`endif
);

   logic [cnt_width_p-1:0] r_count;

`ifdef BP_NONSYNTH_STALL_HIST_SATURATE_EN
   assign next_count_o = (inc_i && (r_count != '1)) ? r_count + cnt_width_p'(1) : r_count;
`else
   logic r_overflow;

   assign next_count_o    = inc_i ? r_count + cnt_width_p'(1) : r_count;
   assign next_overflow_o = r_overflow | (inc_i & (&r_count));

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         r_overflow <= 1'b0;
      else
         r_overflow <= clear_i ? 1'b0 : next_overflow_o;
   end
`endif

   // Clear wins over the increment; the snapshot still sees next_count_o
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         r_count <= '0;
      else
         r_count <= clear_i ? '0 : next_count_o;
   end

endmodule

`default_nettype wire

// File: rtl/bp_nonsynth_stall_histogram.sv
// ============================================================================
// Module : bp_nonsynth_stall_histogram
// Bins every enabled cycle by commit / stall reason and streams a snapshot of
// all bins over valid/ready. Option macro: BP_NONSYNTH_STALL_HIST_SATURATE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_nonsynth_stall_histogram
   import bp_be_pkg::*;
#(
   parameter  int num_reasons_p   = c_num_reasons,
   parameter  int cnt_width_p     = 32,
   localparam int num_bins_lp     = num_reasons_p + 3,
   localparam int bin_id_width_lp = $clog2(num_bins_lp)
)(
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       en_i,
   input  logic                       commit_v_i,
   input  logic [num_reasons_p-1:0]   stall_reason_i,
   input  logic                       clear_i,
   input  logic                       dump_i,
   output logic                       dump_v_o,
   input  logic                       dump_ready_i,
   output logic [bin_id_width_lp-1:0] dump_id_o,
   output logic [cnt_width_p-1:0]     dump_count_o,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int c_unattr_bin = num_reasons_p;
   localparam int c_commit_bin = num_reasons_p + 1;
   localparam int c_total_bin  = num_reasons_p + 2;
   localparam logic [bin_id_width_lp-1:0] c_last_id = bin_id_width_lp'(num_bins_lp - 1);

   logic                     w_stall_cycle;
   logic [num_reasons_p-1:0] w_lowest;
   logic [num_bins_lp-1:0]   w_inc;

   assign w_stall_cycle = en_i & ~commit_v_i;
   // Two's-complement trick isolates the lowest set (highest priority) reason
   assign w_lowest      = stall_reason_i & (~stall_reason_i + num_reasons_p'(1));

   always_comb begin
      w_inc = '0;
      if (w_stall_cycle)
         w_inc[num_reasons_p-1:0] = w_lowest;
      w_inc[c_unattr_bin] = w_stall_cycle & ~(|stall_reason_i);
      w_inc[c_commit_bin] = en_i & commit_v_i;
      w_inc[c_total_bin]  = en_i;
   end

   logic [cnt_width_p-1:0] w_next_count [num_bins_lp];
`ifndef BP_NONSYNTH_STALL_HIST_SATURATE_EN
   logic [num_bins_lp-1:0] w_next_ovf;
`endif

   for (genvar gi = 0; gi < num_bins_lp; gi++) begin : g_bins
      bp_nonsynth_stall_counter #(
         .cnt_width_p (cnt_width_p)
      ) u_cnt (
         .clk_i           (clk_i),
         .reset_i         (reset_i),
         .clear_i         (clear_i),
         .inc_i           (w_inc[gi]),
         .next_count_o    (w_next_count[gi])
`ifndef BP_NONSYNTH_STALL_HIST_SATURATE_EN
         ,
         .next_overflow_o (w_next_ovf[gi])
`endif
      );
   end

   bp_stall_dump_state_e       r_state, w_state_next;
   logic [bin_id_width_lp-1:0] r_index, w_index_next;
   logic                       r_done, w_done_next;
   logic                       w_load;
   logic [cnt_width_p-1:0]     r_snap [num_bins_lp];

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= e_dump_idle;
         r_index <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_index <= w_index_next;
         r_done  <= w_done_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_index_next = r_index;
      w_done_next  = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         e_dump_idle: begin
            if (dump_i) begin
               w_state_next = e_dump_active;
               w_index_next = '0;
               w_load       = 1'b1;
            end
         end
         e_dump_active: begin
            if (dump_ready_i) begin
               if (r_index == c_last_id) begin
                  w_state_next = e_dump_idle;
                  w_index_next = '0;
                  w_done_next  = 1'b1;
               end else begin
                  w_index_next = r_index + bin_id_width_lp'(1);
               end
            end
         end
         default: begin
            w_state_next = e_dump_idle;
            w_index_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < num_bins_lp; i++)
            r_snap[i] <= '0;
      end else if (w_load) begin
         for (int i = 0; i < num_bins_lp; i++)
            r_snap[i] <= w_next_count[i];
      end
   end

   assign dump_v_o     = (r_state == e_dump_active);
   assign busy_o       = dump_v_o;
   assign done_o       = r_done;
   assign dump_id_o    = r_index;
   assign dump_count_o = dump_v_o ? r_snap[r_index] : '0;

`ifndef BP_NONSYNTH_STALL_HIST_SATURATE_EN
   logic [num_bins_lp-1:0] r_snap_ovf;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         r_snap_ovf <= '0;
      else if (w_load)
         r_snap_ovf <= w_next_ovf;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!reset_i && dump_v_o && dump_ready_i && r_snap_ovf[r_index])
         $warning("stall histogram bin %0d wrapped, dumped value %0d", r_index, dump_count_o);
   end
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_nonsynth_stall_histogram.sv
// ============================================================================
// Module : tb_bp_nonsynth_stall_histogram
// Scoreboard bench: reference bin model feeds expected dump entries to a queue
// that a negedge monitor pops on each handshake (32-bit and 4-bit instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bp_nonsynth_stall_histogram;

   localparam int c_nb = 13;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        en_i = 1'b0, commit_v_i = 1'b0, clear_i = 1'b0, dump_i = 1'b0, dump_ready_i = 1'b0;
   logic [9:0]  stall_reason_i = '0;
   logic        dump_v_o, busy_o, done_o, v4, busy4, done4;
   logic [3:0]  dump_id_o, id4;
   logic [31:0] dump_count_o;
   logic [3:0]  cnt4;

   always #5 clk = ~clk;

   bp_nonsynth_stall_histogram dut (
      .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .commit_v_i(commit_v_i),
      .stall_reason_i(stall_reason_i), .clear_i(clear_i), .dump_i(dump_i),
      .dump_v_o(dump_v_o), .dump_ready_i(dump_ready_i), .dump_id_o(dump_id_o),
      .dump_count_o(dump_count_o), .busy_o(busy_o), .done_o(done_o));

   bp_nonsynth_stall_histogram #(.cnt_width_p(4)) dut4 (
      .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .commit_v_i(commit_v_i),
      .stall_reason_i(stall_reason_i), .clear_i(clear_i), .dump_i(dump_i),
      .dump_v_o(v4), .dump_ready_i(dump_ready_i), .dump_id_o(id4),
      .dump_count_o(cnt4), .busy_o(busy4), .done_o(done4));

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] cnt;
      logic [3:0]  cnt4;
   } entry_t;

   entry_t      sb[$];
   int unsigned m  [c_nb];
   int unsigned m4 [c_nb];
   bit          done_pend = 1'b0;
   int          n_total = 0;
   int          n_bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned bump4(input int unsigned v);
`ifdef BP_NONSYNTH_STALL_HIST_SATURATE_EN
      return (v == 15) ? 15 : v + 1;
`else
      return (v + 1) & 15;
`endif
   endfunction

   // One clock of stimulus; the model advances alongside the DUT
   task automatic cycle(input bit en, input bit cm, input logic [9:0] rs,
                        input bit clr, input bit dmp, input bit rdy);
      int unsigned nx  [c_nb];
      int unsigned nx4 [c_nb];
      bit          incv [c_nb];
      bit          found;
      bit          accept;
      en_i = en; commit_v_i = cm; stall_reason_i = rs;
      clear_i = clr; dump_i = dmp; dump_ready_i = rdy;
      for (int b = 0; b < c_nb; b++) incv[b] = 1'b0;
      if (en) begin
         incv[12] = 1'b1;
         if (cm) incv[11] = 1'b1;
         else begin
            found = 1'b0;
            for (int i = 0; i < 10; i++)
               if (!found && rs[i]) begin
                  incv[i] = 1'b1;
                  found   = 1'b1;
               end
            if (!found) incv[10] = 1'b1;
         end
      end
      for (int b = 0; b < c_nb; b++) begin
         nx[b]  = incv[b] ? m[b] + 1 : m[b];
         nx4[b] = incv[b] ? bump4(m4[b]) : m4[b];
         m[b]   = clr ? 0 : nx[b];
         m4[b]  = clr ? 0 : nx4[b];
      end
      accept = dmp && (sb.size() == 0);
      @(posedge clk);
      if (accept)
         for (int b = 0; b < c_nb; b++)
            sb.push_back('{id: 4'(b), cnt: nx[b], cnt4: 4'(nx4[b])});
      #1;
   endtask

   task automatic drain(input bit toggle);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, toggle ? (n % 2 == 0) : 1'b1);
         n++;
      end
      check("drain_left", sb.size(), 0);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   always @(negedge clk) begin
      if (!reset_i) begin
         if (done_pend || done_o || done4) begin
            check("done", done_o, done_pend);
            check("done4", done4, done_pend);
         end
         done_pend = 1'b0;
         if (dump_v_o || sb.size() != 0) begin
            check("busy", busy_o, sb.size() != 0);
            check("valid4", v4, sb.size() != 0);
         end
         if (dump_v_o && sb.size() == 0)
            check("valid_unexpected", dump_v_o, 1'b0);
         else if (sb.size() != 0) begin
            check("valid", dump_v_o, 1'b1);
            check("id", dump_id_o, sb[0].id);
            check("id4", id4, sb[0].id);
            check("count", dump_count_o, sb[0].cnt);
            check("count4", cnt4, sb[0].cnt4);
            if (dump_v_o && dump_ready_i) begin
               void'(sb.pop_front());
               if (sb.size() == 0) done_pend = 1'b1;
            end
         end
      end
   end

   initial begin
      for (int b = 0; b < c_nb; b++) begin m[b] = 0; m4[b] = 0; end
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", dump_v_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_id", dump_id_o, 0);
      check("rst_count", dump_count_o, 0);
      reset_i = 1'b0;
      cycle(0, 0, '0, 0, 0, 1);

      // 100 commits then a full-rate dump
      repeat (100) cycle(1, 1, '0, 0, 0, 1);
      cycle(0, 0, '0, 0, 1, 1);
      drain(1'b0);
      cycle(0, 0, '0, 1, 0, 1);

      // reason priority and unattributed cycles, dumped with ready toggling
      repeat (5) cycle(1, 0, 10'b0000001100, 0, 0, 0);
      repeat (3) cycle(1, 0, '0, 0, 0, 0);
      cycle(0, 0, '0, 0, 1, 1);
      drain(1'b1);

      // dump and clear together after 7 commits, then a dump of cleared state
      cycle(0, 0, '0, 1, 0, 1);
      repeat (7) cycle(1, 1, '0, 0, 0, 1);
      cycle(1, 1, '0, 1, 1, 1);
      drain(1'b0);
      cycle(0, 0, '0, 0, 1, 1);
      drain(1'b0);

      // random traffic, with counting, clear and a stray dump_i during the dump
      repeat (40) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                        ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(0, 1023)), 0, 0, 1);
      cycle(1, 0, 10'b1000000000, 0, 1, 0);
      cycle(1, 1, '0, 0, 1, 1);
      cycle(1, 0, 10'b0101000000, 0, 0, 0);
      cycle(1, 0, '0, 1, 0, 1);
      cycle(1, 0, 10'b0000100000, 0, 0, 1);
      drain(1'b1);
      cycle(0, 0, '0, 0, 1, 1);
      drain(1'b0);

      // reset asserted with entry 5 on the bus
      repeat (9) cycle(1, 1, '0, 0, 0, 1);
      cycle(0, 0, '0, 0, 1, 1);
      for (int n = 0; n < 50 && sb.size() > 8; n++) cycle(0, 0, '0, 0, 0, 1);
      check("pre_reset_id", dump_id_o, 5);
      #2 reset_i = 1'b1;
      #1;
      check("async_valid", dump_v_o, 0);
      check("async_busy", busy_o, 0);
      check("async_valid4", v4, 0);
      sb.delete();
      done_pend = 1'b0;
      for (int b = 0; b < c_nb; b++) begin m[b] = 0; m4[b] = 0; end
      @(posedge clk);
      #1 reset_i = 1'b0;
      check("post_reset_id", dump_id_o, 0);
      repeat (3) cycle(0, 0, '0, 0, 0, 1);
      cycle(0, 0, '0, 0, 1, 1);
      drain(1'b0);

      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
